// File: rtl/mem_arb_pkg.sv
// Shared types and access-type encodings for the data-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

   // [1:0] size (00 byte, 01 half, 1x word), [2] zero-extend
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority LSU/IFU grant selection with a starvation counter that
// forces an IFU grant after STARVE_MAX back-to-back LSU grants.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ifu_valid,
   input  logic lsu_valid,
   input  logic idle,
   input  logic ifu_fire,
   input  logic lsu_fire,
   output logic grant_ifu,
   output logic grant_lsu
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;

   // NOTE: every output gets a default before the if-chain, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      if (idle) begin
         if (lsu_valid && (starve_cnt < CNT_MAX)) begin
            grant_lsu = 1'b1;
         end else if (ifu_valid) begin
            grant_ifu = 1'b1;
         end else if (lsu_valid) begin
            grant_lsu = 1'b1;
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // pre-edge values regardless of statement or process order.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (ifu_fire) begin
         starve_cnt <= '0;
      end else if (idle && !ifu_valid) begin
         starve_cnt <= '0;
      end else if (lsu_fire && ifu_valid && (starve_cnt != CNT_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing the data memory between IFU and LSU:
// grant in IDLE, drive memory in BUSY for MEM_LAT cycles, respond in RESP.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_req_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_resp_data,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_req_addr,
   input  logic              lsu_req_wen,
   input  logic [2:0]        lsu_req_type,
   input  logic [DATA_W-1:0] lsu_req_wdata,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_resp_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [2:0]        mem_rw_type,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

   state_t           state;
   state_t           state_next;
   owner_t           owner;
   logic [LAT_W-1:0] lat_cnt;
   logic             lat_wen;
   logic             wr_first;
   logic             capture;
   logic             idle;
   logic             grant_ifu;
   logic             grant_lsu;
   logic             ifu_fire;
   logic             lsu_fire;

   // Gating with rst keeps readies low while reset is held, even in IDLE.
   assign idle     = (state == IDLE) && !rst;
   assign ifu_fire = ifu_req_valid && ifu_req_ready;
   assign lsu_fire = lsu_req_valid && lsu_req_ready;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clk       (clk),
      .rst       (rst),
      .ifu_valid (ifu_req_valid),
      .lsu_valid (lsu_req_valid),
      .idle      (idle),
      .ifu_fire  (ifu_fire),
      .lsu_fire  (lsu_fire),
      .grant_ifu (grant_ifu),
      .grant_lsu (grant_lsu)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      capture        = 1'b0;
      case (state)
         IDLE: begin
            ifu_req_ready = grant_ifu;
            lsu_req_ready = grant_lsu;
            if (grant_ifu || grant_lsu) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (lat_cnt == '0) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            ifu_resp_valid = !rst && (owner == OWN_IFU);
            lsu_resp_valid = !rst && (owner == OWN_LSU);
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A store whose first BUSY cycle coincides with rst must not reach memory.
   assign mem_wr_en = wr_first && !rst;

   // NOTE: the request latch and response registers are cleared on reset because
   // they drive outputs directly; there is no storage array here to leave unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr      <= '0;
         mem_rw_type   <= '0;
         mem_wdata     <= '0;
         lat_wen       <= 1'b0;
         wr_first      <= 1'b0;
         owner         <= OWN_IFU;
         lat_cnt       <= '0;
         ifu_resp_data <= '0;
         lsu_resp_data <= '0;
      end else begin
         wr_first <= 1'b0;
         if (grant_lsu) begin
            mem_addr    <= lsu_req_addr;
            mem_rw_type <= lsu_req_type;
            mem_wdata   <= lsu_req_wdata;
            lat_wen     <= lsu_req_wen;
            wr_first    <= lsu_req_wen;
            owner       <= OWN_LSU;
            lat_cnt     <= LAT_INIT;
         end else if (grant_ifu) begin
            mem_addr    <= ifu_req_addr;
            mem_rw_type <= LW;
            mem_wdata   <= '0;
            lat_wen     <= 1'b0;
            owner       <= OWN_IFU;
            lat_cnt     <= LAT_INIT;
         end else if ((state == BUSY) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 1'b1;
         end

         if (capture) begin
            if (owner == OWN_IFU) begin
               ifu_resp_data <= mem_rdata;
            end else begin
               lsu_resp_data <= lat_wen ? '0 : mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: handshakes push expected responses, a monitor pops and
// compares them whenever a response valid is presented.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] ifu_req_addr, lsu_req_addr, lsu_req_wdata;
   logic        lsu_req_wen;
   logic [2:0]  lsu_req_type;

   logic        ifu_req_valid, lsu_req_valid, ifu_req_ready, lsu_req_ready;
   logic        ifu_resp_valid, lsu_resp_valid, mem_wr_en;
   logic [31:0] ifu_resp_data, lsu_resp_data, mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_rw_type;

   logic        l3_ifu_valid, l3_lsu_valid, l3_ifu_ready, l3_lsu_ready;
   logic        l3_ifu_rv, l3_lsu_rv, l3_mem_wr_en;
   logic [31:0] l3_ifu_rd, l3_lsu_rd, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;
   logic [2:0]  l3_mem_rw_type;

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return (a == 32'h8000_0004) ? 32'h0010_0093 : (a ^ 32'h5A5A_5A5A);
   endfunction

   assign mem_rdata    = rd_fn(mem_addr);
   assign l3_mem_rdata = 32'hA000_0000 + 32'(cyc);

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_type(lsu_req_type), .lsu_req_wdata(lsu_req_wdata),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rw_type(mem_rw_type),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
      .clk(clk), .rst(rst),
      .ifu_req_valid(l3_ifu_valid), .ifu_req_ready(l3_ifu_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_resp_valid(l3_ifu_rv), .ifu_resp_data(l3_ifu_rd),
      .lsu_req_valid(l3_lsu_valid), .lsu_req_ready(l3_lsu_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_type(lsu_req_type), .lsu_req_wdata(lsu_req_wdata),
      .lsu_resp_valid(l3_lsu_rv), .lsu_resp_data(l3_lsu_rd),
      .mem_addr(l3_mem_addr), .mem_wr_en(l3_mem_wr_en), .mem_rw_type(l3_mem_rw_type),
      .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t q_ifu[$];
   exp_t q_lsu[$];
   exp_t q_l3[$];
   bit   grant_log[$];   // 1 = IFU, 0 = LSU
   int   l3_hs[$];
   int   wr_pulses = 0;

   // Handshake observer: builds expectations from the request inputs alone.
   always @(negedge clk) begin
      if (!rst) begin
         if (ifu_req_ready || lsu_req_ready)
            check("one_ready", 32'(ifu_req_ready & lsu_req_ready), 32'd0);
         if (ifu_req_valid && ifu_req_ready) begin
            q_ifu.push_back('{data: rd_fn(ifu_req_addr), due: cyc + 2});
            grant_log.push_back(1'b1);
         end
         if (lsu_req_valid && lsu_req_ready) begin
            q_lsu.push_back('{data: lsu_req_wen ? 32'd0 : rd_fn(lsu_req_addr), due: cyc + 2});
            grant_log.push_back(1'b0);
         end
         if (l3_lsu_valid && l3_lsu_ready) begin
            q_l3.push_back('{data: 32'hA000_0000 + 32'(cyc + 3), due: cyc + 4});
            l3_hs.push_back(cyc);
         end
      end
      if (mem_wr_en === 1'b1) wr_pulses++;
   end

   // Response monitor.
   always @(negedge clk) begin
      exp_t e;
      if (ifu_resp_valid === 1'b1) begin
         if (q_ifu.size() == 0) fail("ifu_resp_unexpected");
         else begin
            e = q_ifu.pop_front();
            check("ifu_resp_data", ifu_resp_data, e.data);
            check("ifu_resp_cycle", 32'(cyc), 32'(e.due));
         end
      end
      if (lsu_resp_valid === 1'b1) begin
         if (q_lsu.size() == 0) fail("lsu_resp_unexpected");
         else begin
            e = q_lsu.pop_front();
            check("lsu_resp_data", lsu_resp_data, e.data);
            check("lsu_resp_cycle", 32'(cyc), 32'(e.due));
         end
      end
      if (l3_lsu_rv === 1'b1) begin
         if (q_l3.size() == 0) fail("l3_resp_unexpected");
         else begin
            e = q_l3.pop_front();
            check("l3_resp_data", l3_lsu_rd, e.data);
            check("l3_resp_cycle", 32'(cyc), 32'(e.due));
         end
      end
      if (l3_ifu_rv === 1'b1) fail("l3_ifu_resp_unexpected");
   end

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (q_ifu.size() == 0 && q_lsu.size() == 0 && q_l3.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) fail("drain_timeout");
      @(posedge clk); #1;
   endtask

   task automatic issue(input bit is_lsu, input logic [31:0] addr, input logic wen,
                        input logic [2:0] typ, input logic [31:0] wdata, output int t_hs);
      bit hs = 1'b0;
      @(posedge clk); #1;
      if (is_lsu) begin
         lsu_req_addr = addr; lsu_req_wen = wen; lsu_req_type = typ; lsu_req_wdata = wdata;
         lsu_req_valid = 1'b1;
      end else begin
         ifu_req_addr = addr;
         ifu_req_valid = 1'b1;
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (is_lsu ? lsu_req_ready : ifu_req_ready) begin
            hs = 1'b1;
            break;
         end
      end
      if (!hs) fail("handshake_timeout");
      t_hs = cyc;
      @(posedge clk); #1;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int  t;
      bit  got;
      bit  exp_order [10];

      ifu_req_addr  = 32'h8000_0100;
      lsu_req_addr  = 32'h0000_2000;
      lsu_req_wen   = 1'b0;
      lsu_req_type  = LW;
      lsu_req_wdata = 32'd0;
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      l3_ifu_valid  = 1'b0;
      l3_lsu_valid  = 1'b0;
      rst           = 1'b1;

      // Reset held three cycles with both requests pending.
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         check("rst_readies", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
         check("rst_resp_valids", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
      end
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
      check("rst_mem_rw_type", 32'(mem_rw_type), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_ifu_resp_data", ifu_resp_data, 32'd0);
      check("rst_lsu_resp_data", lsu_resp_data, 32'd0);

      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("first_lsu_ready", 32'(lsu_req_ready), 32'd1);
      check("first_ifu_ready", 32'(ifu_req_ready), 32'd0);

      // Contention: both valids held until ten grants are observed.
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (grant_log.size() >= 10) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) fail("contention_timeout");
      @(posedge clk); #1;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      if (got) begin
         for (int i = 0; i < 10; i++)
            check($sformatf("grant_order[%0d]", i), 32'(grant_log[i]), 32'(exp_order[i]));
      end
      drain();

      // Single fetch.
      wr_pulses = 0;
      issue(1'b0, 32'h8000_0004, 1'b0, LW, 32'd0, t);
      @(negedge clk);
      check("fetch_mem_addr", mem_addr, 32'h8000_0004);
      check("fetch_mem_rw_type", 32'(mem_rw_type), 32'(LW));
      drain();
      check("fetch_no_write", 32'(wr_pulses), 32'd0);

      // Halfword store.
      wr_pulses = 0;
      issue(1'b1, 32'h8000_0102, 1'b1, LH, 32'h0000_BEEF, t);
      @(negedge clk);
      check("store_wr_en", 32'(mem_wr_en), 32'd1);
      check("store_rw_type", 32'(mem_rw_type), 32'b001);
      check("store_addr", mem_addr, 32'h8000_0102);
      check("store_wdata", mem_wdata, 32'h0000_BEEF);
      @(negedge clk);
      check("store_wr_en_off", 32'(mem_wr_en), 32'd0);
      drain();
      check("store_wr_pulses", 32'(wr_pulses), 32'd1);

      // Zero-extending byte load, then a fetch: LSU response data must hold.
      issue(1'b1, 32'h0000_3000, 1'b0, LBU, 32'd0, t);
      @(negedge clk);
      check("lbu_rw_type", 32'(mem_rw_type), 32'(LBU));
      drain();
      issue(1'b0, 32'h8000_0040, 1'b0, LW, 32'd0, t);
      drain();
      check("lsu_data_hold", lsu_resp_data, rd_fn(32'h0000_3000));

      // MEM_LAT=3 instance: two back-to-back loads with changing mem_rdata.
      @(posedge clk); #1;
      lsu_req_addr = 32'h0000_4000; lsu_req_wen = 1'b0; lsu_req_type = LW;
      l3_lsu_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (l3_hs.size() >= 2) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail("l3_timeout");
      @(posedge clk); #1 l3_lsu_valid = 1'b0;
      if (got) check("l3_throughput", 32'(l3_hs[1] - l3_hs[0]), 32'd5);
      drain();

      // Reset in the first BUSY cycle of a store.
      wr_pulses = 0;
      issue(1'b1, 32'h8000_0200, 1'b1, LW, 32'h1234_5678, t);
      rst = 1'b1;
      q_lsu.delete();
      @(negedge clk);
      check("rst_busy_wr_en", 32'(mem_wr_en), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      lsu_req_addr = 32'h0000_5000; lsu_req_wen = 1'b0; lsu_req_type = LW;
      lsu_req_valid = 1'b1;
      @(negedge clk);
      check("rst_busy_idle_ready", 32'(lsu_req_ready), 32'd1);
      check("rst_busy_addr_cleared", mem_addr, 32'd0);
      @(posedge clk); #1 lsu_req_valid = 1'b0;
      drain();
      check("rst_busy_no_write", 32'(wr_pulses), 32'd0);

      check("queues_empty", 32'(q_ifu.size() + q_lsu.size() + q_l3.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported data memory between the instruction-fetch unit (IFU) and the load/store unit (LSU). Each requester has a valid/ready request channel and a valid-only response channel. The block allows one transaction in flight at a time. It drives the memory's address, write-enable, access type and write data, and returns read data to the requester that owns the transaction. LSU has fixed priority. A starvation counter forces an IFU grant after a bounded number of back-to-back LSU grants.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, cycles from request issue to mem_rdata valid (>=1)
STARVE_MAX, 4, consecutive LSU grants allowed while IFU is waiting (>=1)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_req_addr  in  ADDR_W  fetch address (word access)
ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
ifu_resp_data  out  DATA_W  fetched word
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_addr  in  ADDR_W  byte address
lsu_req_wen  in  1  1 = store, 0 = load
lsu_req_type  in  3  access type: [1:0] 00 byte / 01 half / 1x word; [2] = zero-extend
lsu_req_wdata  in  DATA_W  store data
lsu_resp_valid  out  1  one-cycle pulse: load data valid, or store done
lsu_resp_data  out  DATA_W  load data; 0 for stores
mem_addr  out  ADDR_W  memory address
mem_wr_en  out  1  memory write strobe
mem_rw_type  out  3  memory access type
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data (already extended by the memory)

Behaviour:
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- Reset clears every output to 0: readies, resp_valids, resp_datas, all mem_* outputs. It also clears the latched request, the owner, the latency counter and the starvation counter. rst has priority over all other inputs.
- IDLE, grant selection:
  - If lsu_req_valid is high and the starvation counter is below STARVE_MAX, grant LSU.
  - Otherwise, if ifu_req_valid is high, grant IFU.
  - Otherwise, if lsu_req_valid is high, grant LSU.
- The selected ready is driven combinationally in IDLE only. The handshake is valid&&ready. At most one ready is high in any cycle.
- On handshake:
  - Latch addr, wen, type and wdata. IFU requests use wen=0 and type=3'b010.
  - Record the owner, load the latency counter with MEM_LAT-1, and go to BUSY.
- BUSY:
  - mem_addr, mem_rw_type and mem_wdata come from the latch for every BUSY cycle.
  - mem_wr_en is 1 only in the first BUSY cycle, and only for stores.
  - The counter decrements each cycle. When it reaches 0, capture mem_rdata (stores capture 0) and go to RESP.
- RESP:
  - The owner's resp_valid is 1 for exactly one cycle, with resp_data set to the captured value.
  - The next state is IDLE. No ready is high during RESP.
- Outside BUSY, mem_wr_en is 0. mem_addr, mem_rw_type and mem_wdata hold their last latched values.
- resp_data holds its value until the next response to the same requester.
- Latency: handshake in cycle T gives resp_valid in cycle T+MEM_LAT+1. Peak throughput is one transaction per MEM_LAT+2 cycles.
- Responses have no back-pressure; requesters must sink the response in the cycle it is presented.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each LSU grant made while ifu_req_valid is high.
  - Clears on an IFU grant, and in any IDLE cycle where ifu_req_valid is low.
- Simultaneous requests: resolved by the IDLE grant rule above. A requester that was not granted keeps its valid high and sees ready=0.
- Request inputs are ignored while not in IDLE.
- Reset during BUSY: the transaction is dropped and no response is given. If rst coincides with the write cycle, mem_wr_en stays 0, so no partial store occurs. The requester reissues.
- Back-to-back: after RESP the block returns to IDLE. The earliest next handshake is one cycle after RESP.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE/BUSY/RESP
  - owner enum: OWN_IFU/OWN_LSU
  - rw_type constants: LB 3'b000, LH 3'b001, LW 3'b010, LBU 3'b100, LHU 3'b101
- One sub-module, mem_arb_pick, contains the priority selection and the starvation counter. Inputs: both valids, idle, and the grant feedback. Outputs: grant_ifu and grant_lsu.
- The FSM, request latch, latency counter and response registers stay in the top module.

Test Plan:
- Reset: hold rst=1 for 3 cycles while both requests are valid -> all outputs 0 and no readies. First cycle after release -> lsu_req_ready=1.
- Single fetch, MEM_LAT=1, ifu addr 0x8000_0004, mem_rdata=0x0010_0093 -> handshake at T, mem_addr=0x8000_0004 at T+1, ifu_resp_valid=1 with data 0x0010_0093 at T+2, mem_wr_en never 1.
- Store: LSU wen=1, type=SH, addr 0x8000_0102, wdata 0xBEEF -> mem_wr_en=1 for exactly 1 cycle with mem_rw_type=3'b001, then lsu_resp_valid=1 with data 0.
- Contention with STARVE_MAX=4: both valids held high -> grant order LSU,LSU,LSU,LSU,IFU,LSU…; never more than 4 consecutive LSU grants.
- MEM_LAT=3 load with mem_rdata changing every cycle -> captured value is the one present 3 cycles after handshake; resp_valid arrives at T+4.
- rst asserted in the first BUSY cycle of a store -> mem_wr_en=0, no lsu_resp_valid, state IDLE the next cycle.
